jt12_wrq: RTL
=============

JT12_WRQ -- requirements
Module: jt12_wrq

Interface
REQ-001 Parameter DEPTH, default 16: write-queue entries, power of two, 2..256.
REQ-002 Parameter WAIT_ADDR, default 6: cen ticks held after a chip address write, 1..255.
REQ-003 Parameter WAIT_DATA, default 17: cen ticks held after a chip data write, 1..255.
REQ-004 Parameter NUM_BANK, default 2: 1 = single register bank (addr[1] ignored, forced 0); 2 = two banks.
REQ-005 Parameter SKIP_ADDR, default 1: 1 = omit chip address phase when bank and register equal the last issued address.
REQ-006 Clock and reset: one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  system clock.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 cen  in  1  chip clock enable; gates all chip-side timing.
REQ-010 din  in  8  host write data.
REQ-011 addr  in  2  host address; bit0 0 = register select, 1 = data; bit1 = bank.
REQ-012 cs_n  in  1  host chip select, active low.
REQ-013 wr_n  in  1  host write strobe, active low.
REQ-014 chip_din  out  8  data bus to jt12_top.
REQ-015 chip_addr  out  2  address bus to jt12_top.
REQ-016 chip_cs_n  out  1  chip select to jt12_top.
REQ-017 chip_wr_n  out  1  write strobe to jt12_top.
REQ-018 level  out  $clog2(DEPTH)+1  queued entry count.
REQ-019 full  out  1  level == DEPTH.
REQ-020 busy  out  1  queue non-empty or FSM not IDLE.
REQ-021 ovf  out  1  sticky overflow flag.
REQ-022 ovf_clr  in  1  clears ovf.

Function
REQ-023 Host write event = (!cs_n && !wr_n) this clk and not last clk; sampled every clk, independent of cen.
REQ-024 Event with addr[0]=0 loads holding register {bank=addr[1], reg=din}; no push.
REQ-025 Event with addr[0]=1 pushes {hold bank, hold reg, din} into the FIFO; level increments next clk.
REQ-026 Push while full and no pop same clk: entry dropped, ovf set next clk, level unchanged.
REQ-027 Push and pop in same clk: both performed, level unchanged, ovf not set even if full.
REQ-028 ovf_clr and overflow in same clk: ovf stays set.
REQ-029 FSM states IDLE, ADDR, WAIT_A, DATA, WAIT_D; transitions only on clk with cen=1.
REQ-030 IDLE, FIFO non-empty: pop head into issue register; go ADDR, or DATA when SKIP_ADDR=1 and {bank,reg} equals last-address register.
REQ-031 ADDR: chip_cs_n=0, chip_wr_n=0, chip_addr={bank,0}, chip_din=reg for one cen tick; update last-address register; load counter WAIT_ADDR; go WAIT_A.
REQ-032 WAIT_A: strobes high; decrement counter per cen; at 1 go DATA.
REQ-033 DATA: chip_cs_n=0, chip_wr_n=0, chip_addr={bank,1}, chip_din=data for one cen tick; load WAIT_DATA; go WAIT_D.
REQ-034 WAIT_D: strobes high; decrement per cen; at 1 go IDLE, eligible to pop on next cen tick.
REQ-035 Strobe pulses last exactly one cen period (from the cen=1 entering clk until the next cen=1 clk).
REQ-036 FIFO pointers wrap modulo DEPTH; order strictly preserved.
REQ-037 Holding register persists; repeated data writes reuse last selected register.
REQ-038 With NUM_BANK=1, bank bit stored and driven as 0.

Reset
REQ-039 On rst: FSM IDLE, FIFO empty, level 0, full 0, busy 0, ovf 0, chip_cs_n 1, chip_wr_n 1, chip_addr 0, chip_din 0, holding register 0, last-address register invalid (next entry always issues ADDR).
REQ-040 rst mid-transfer aborts immediately; strobes high on the next clk; queued entries discarded.
REQ-041 rst dominates all other inputs, including cen=0.

Verification
REQ-042 cen=1, write addr0 0x28, addr1 0xF0 -> ADDR pulse {0,0x28}, 6 cen later DATA pulse {1,0xF0}, busy low 17 cen later.
REQ-043 Two data writes to reg 0xA4 bank1, SKIP_ADDR=1 -> second entry issues only DATA on chip_addr 3.
REQ-044 DEPTH=4, cen=0, five data writes -> level 4, full 1, ovf 1; ovf_clr -> ovf 0.
REQ-045 Full FIFO, push coincident with pop -> level stays 4, ovf stays 0, order preserved.
REQ-046 rst asserted during WAIT_A -> chip_cs_n=1, level 0, busy 0 next clk; subsequent write issues ADDR.
REQ-047 cen every 4th clk -> all waits measured in cen ticks: ADDR-to-DATA spacing = 24 clk.

Source files
------------

// File: rtl/jt12_wrq.sv
// rtl/jt12_wrq.sv - host write queue with cen-paced address/data issue to jt12_top
module jt12_wrq #(
  parameter int DEPTH     = 16,
  parameter int WAIT_ADDR = 6,
  parameter int WAIT_DATA = 17,
  parameter int NUM_BANK  = 2,
  parameter int SKIP_ADDR = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cen,
  input  logic [7:0]               din,
  input  logic [1:0]               addr,
  input  logic                     cs_n,
  input  logic                     wr_n,
  input  logic                     ovf_clr,
  output logic [7:0]               chip_din,
  output logic [1:0]               chip_addr,
  output logic                     chip_cs_n,
  output logic                     chip_wr_n,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     busy,
  output logic                     ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT_A, S_DATA, S_WAIT_D} state_t;

  // Queue entry layout: {bank, reg[7:0], data[7:0]}
  logic [16:0]   mem_q [DEPTH];
  state_t        state_q, state_d;
  logic          wr_prev_q, wr_prev_d;
  logic          hold_bank_q, hold_bank_d;
  logic [7:0]    hold_reg_q, hold_reg_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          iss_bank_q, iss_bank_d;
  logic [7:0]    iss_data_q, iss_data_d;
  logic [8:0]    last_q, last_d;
  logic          last_v_q, last_v_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          stb_q, stb_d;
  logic [1:0]    caddr_q, caddr_d;
  logic [7:0]    cdin_q, cdin_d;
  logic          wr_act, wr_ev, push, pop, push_ok, full_w;
  logic [16:0]   head;

  // Host edge detect, queue bookkeeping and the issue FSM
  always_comb begin
    wr_act      = !cs_n && !wr_n;
    wr_ev       = wr_act && !wr_prev_q;
    wr_prev_d   = wr_act;
    full_w      = (level_q == LW'(DEPTH));
    head        = mem_q[rd_ptr_q];
    push        = wr_ev && addr[0];
    pop         = cen && (state_q == S_IDLE) && (level_q != '0);
    push_ok     = push && (!full_w || pop);

    hold_bank_d = hold_bank_q;
    hold_reg_d  = hold_reg_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    ovf_d       = ovf_q;
    state_d     = state_q;
    iss_bank_d  = iss_bank_q;
    iss_data_d  = iss_data_q;
    last_d      = last_q;
    last_v_d    = last_v_q;
    cnt_d       = cnt_q;
    stb_d       = stb_q;
    caddr_d     = caddr_q;
    cdin_d      = cdin_q;

    if (wr_ev && !addr[0]) begin
      hold_bank_d = (NUM_BANK == 2) ? addr[1] : 1'b0;
      hold_reg_d  = din;
    end

    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop)      level_d = level_q + 1'b1;
    else if (!push_ok && pop) level_d = level_q - 1'b1;

    // A set from a dropped push wins over a same-cycle clear
    if (ovf_clr)           ovf_d = 1'b0;
    if (push && !push_ok)  ovf_d = 1'b1;

    // The counter includes the strobe tick, so ADDR-to-DATA spans WAIT_ADDR cen ticks
    if (cen) begin
      case (state_q)
        S_IDLE: begin
          if (level_q != '0) begin
            iss_bank_d = head[16];
            iss_data_d = head[7:0];
            stb_d      = 1'b0;
            if ((SKIP_ADDR != 0) && last_v_q && (head[16:8] == last_q)) begin
              state_d = S_DATA;
              caddr_d = {head[16], 1'b1};
              cdin_d  = head[7:0];
            end else begin
              state_d  = S_ADDR;
              caddr_d  = {head[16], 1'b0};
              cdin_d   = head[15:8];
              last_d   = head[16:8];
              last_v_d = 1'b1;
            end
          end
        end
        S_ADDR: begin
          stb_d   = 1'b1;
          cnt_d   = 8'(WAIT_ADDR - 1);
          state_d = S_WAIT_A;
        end
        S_WAIT_A: begin
          if (cnt_q <= 8'd1) begin
            state_d = S_DATA;
            stb_d   = 1'b0;
            caddr_d = {iss_bank_q, 1'b1};
            cdin_d  = iss_data_q;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        S_DATA: begin
          stb_d   = 1'b1;
          cnt_d   = 8'(WAIT_DATA - 1);
          state_d = S_WAIT_D;
        end
        S_WAIT_D: begin
          if (cnt_q <= 8'd1) state_d = S_IDLE;
          else               cnt_d   = cnt_q - 8'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers; reset wins over every other input
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_prev_q   <= 1'b0;
      hold_bank_q <= 1'b0;
      hold_reg_q  <= 8'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ovf_q       <= 1'b0;
      iss_bank_q  <= 1'b0;
      iss_data_q  <= 8'd0;
      last_q      <= 9'd0;
      last_v_q    <= 1'b0;
      cnt_q       <= 8'd0;
      stb_q       <= 1'b1;
      caddr_q     <= 2'd0;
      cdin_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      wr_prev_q   <= wr_prev_d;
      hold_bank_q <= hold_bank_d;
      hold_reg_q  <= hold_reg_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      ovf_q       <= ovf_d;
      iss_bank_q  <= iss_bank_d;
      iss_data_q  <= iss_data_d;
      last_q      <= last_d;
      last_v_q    <= last_v_d;
      cnt_q       <= cnt_d;
      stb_q       <= stb_d;
      caddr_q     <= caddr_d;
      cdin_q      <= cdin_d;
    end
  end

  // Queue storage; stale contents are harmless because pointers reset
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {hold_bank_q, hold_reg_q, din};
  end

  assign chip_cs_n = stb_q;
  assign chip_wr_n = stb_q;
  assign chip_addr = caddr_q;
  assign chip_din  = cdin_q;
  assign level     = level_q;
  assign full      = full_w;
  assign busy      = (level_q != '0) || (state_q != S_IDLE);
  assign ovf       = ovf_q;
endmodule
